mmio_input_bank: RTL and testbench
==================================

// Module: mmio_input_bank
// PURPOSE
//   Parametrised memory-mapped input bank for external input sources (controller,
//   music). Synchronises and debounces NUM_CH channels of CH_WIDTH bits each and
//   latches rising edges as sticky events. The CPU reads it over the data-memory
//   bus with the same 1-cycle synchronous-read timing as block RAM.
//   data_out is 0 on non-hit cycles so the top level ORs it onto the RAM read data.
// PARAMETERS
//   NUM_CH           2        number of input channels (1..16)
//   CH_WIDTH         5        bits per channel (1..16)
//   BASE_ADDR        16'hF000 first word address of the bank
//   DEBOUNCE_CYCLES  4        stable cycles required before the level changes (>=1)
// PORTS
//   clk          input   1                   system clock, rising edge
//   reset        input   1                   synchronous, active-high
//   addr         input   16                  CPU word address
//   write_en     input   1                   CPU write strobe
//   data_in      input   16                  CPU write data
//   data_out     output  16                  registered read data, 0 when not selected
//   hit          output  1                   registered: previous-cycle addr was in bank
//   ch_in        input   NUM_CH*CH_WIDTH     async inputs; channel i = bits [i*CH_WIDTH +: CH_WIDTH]
//   event_any    output  1                   OR of all sticky event bits
// BEHAVIOUR
// - Register map (word offsets from BASE_ADDR), with bank size N = 2*NUM_CH+1 words:
//     2i   LEVEL_i   RO   debounced level of channel i, zero-extended
//     2i+1 EVENT_i   R/W1C sticky rising-edge flags of channel i; read-to-clear
//     2*NUM_CH SUMMARY RO  bit i = |EVENT_i (i<NUM_CH), other bits 0
// - Selection: sel = (addr >= BASE_ADDR) && (addr < BASE_ADDR+N), compared in 17 bits.
//   Wrap-around above 16'hFFFF is not possible.
// - Reset: data_out=0, hit=0, event_any=0; all sync, debounced and event registers
//   and counters are 0. Reset takes priority over every other action.
// - Synchroniser: each bit passes 2 flops (s1, s2).
// - Debounce: there is one counter cnt per bit, width $clog2(DEBOUNCE_CYCLES)+1.
//   On each edge:
//     if s2==deb:                        cnt<=0
//     else if cnt==DEBOUNCE_CYCLES-1:    deb<=s2, cnt<=0
//     else:                              cnt<=cnt+1
//   A level applied before edge k appears in deb at edge k+1+DEBOUNCE_CYCLES.
//   Pulses shorter than DEBOUNCE_CYCLES cycles at s2 never reach deb.
// - Event set: an EVENT bit is set on the same edge its deb bit goes 0->1.
//   Falling edges set nothing.
// - Read: on an edge with sel && !write_en:
//     data_out <= the register value before that edge (1-cycle latency); hit<=1.
//   On non-sel edges: data_out<=0, hit<=0.
// - Read-to-clear: a read of EVENT_i clears the bits it returned. A set occurring
//   on the same edge wins: the bit stays 1 and is not reported by that read.
// - Write: sel && write_en to EVENT_i clears bits where data_in=1 (set wins on
//   the same edge). Writes to LEVEL or SUMMARY are ignored. On a write edge,
//   data_out<=0 and hit<=1.
// - event_any is registered and reflects the post-edge EVENT contents.
// - Reset mid-debounce discards partial counts. Inputs already stable
//   re-qualify with full latency after reset.
// TESTING (NUM_CH=2, CH_WIDTH=5, DEBOUNCE_CYCLES=4, BASE=F000)
// 1. Hold reset 2 cycles with ch_in=10'h3FF -> data_out=0, hit=0, event_any=0.
//    Then read F000 immediately -> 0.
// 2. ch1=5'b01100 held -> LEVEL_1 (F002) reads 000C from edge 5 after the change.
//    F003 reads 000C, then reads 0000; event_any 1 -> 0.
// 3. ch0 bit0 pulse 3 cycles wide -> LEVEL_0 stays 0 and EVENT_0 stays 0.
//    A 4-cycle pulse -> EVENT_0=0001.
// 4. Pending EVENT_0=0011; write F001 with 0001 -> read F001 returns 0002.
//    Write F000 -> no effect.
// 5. A read of F001 coincides with a new deb rise on bit 2 -> read returns the old
//    bits without bit 2; the next read returns 0004.
// 6. Read F004 with both channels pending -> 0003. Read 0x1234 -> data_out=0, hit=0.
//    Assert reset mid-count (cnt=2) -> level not updated; re-qualifies with 5-edge latency.

Source files
------------

// File: rtl/mmio_input_bank.sv
// Memory-mapped input bank: synchronises and debounces NUM_CH external channels and latches
// rising edges as sticky events, readable over the data bus with one-cycle read latency.
`timescale 1ns/1ps

module mmio_input_bank #(
    parameter int          NUM_CH          = 2,
    parameter int          CH_WIDTH        = 5,
    parameter logic [15:0] BASE_ADDR       = 16'hF000,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                addr,
    input  logic                       write_en,
    input  logic [15:0]                data_in,
    output logic [15:0]                data_out,
    output logic                       hit,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_in,
    output logic                       event_any
);

    localparam int             NB      = NUM_CH * CH_WIDTH;
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int             N_WORDS = 2 * NUM_CH + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]     r_s1;
    logic [NB-1:0]     r_s2;
    logic [NB-1:0]     r_deb;
    logic [NB-1:0]     r_evt;
    logic [CW-1:0]     r_cnt [NB];
    logic [15:0]       r_data_out;
    logic              r_hit;
    logic              r_event_any;

    logic [16:0]       w_addr17;
    logic [16:0]       w_base17;
    logic [16:0]       w_off17;
    logic              w_sel;
    logic [NB-1:0]     w_rise;
    logic [NB-1:0]     w_clr;
    logic [NB-1:0]     w_evt_next;
    logic [NUM_CH-1:0] w_summary;
    logic [15:0]       w_rdata;
    logic              w_unused;

    assign w_addr17 = {1'b0, addr};
    assign w_base17 = {1'b0, BASE_ADDR};
    assign w_off17  = w_addr17 - w_base17;
    assign w_sel    = (w_addr17 >= w_base17) && (w_addr17 < (w_base17 + 17'(N_WORDS)));
    assign w_unused = &{1'b0, data_in};

    // A bit rises exactly when the debouncer is about to commit a 0->1 change.
    always_comb begin
        w_rise = '0;
        for (int b = 0; b < NB; b++) begin
            w_rise[b] = r_s2[b] & ~r_deb[b] & (r_cnt[b] == CNT_MAX);
        end
    end

    always_comb begin
        w_summary = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_summary[i] = |r_evt[i*CH_WIDTH +: CH_WIDTH];
        end
    end

    // Read mux and clear mask; a read of EVENT_i clears exactly the bits it returns.
    always_comb begin
        w_rdata = '0;
        w_clr   = '0;
        if (w_sel) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_off17 == 17'(2 * i)) begin
                    w_rdata[CH_WIDTH-1:0] = r_deb[i*CH_WIDTH +: CH_WIDTH];
                end
                if (w_off17 == 17'(2 * i + 1)) begin
                    w_rdata[CH_WIDTH-1:0] = r_evt[i*CH_WIDTH +: CH_WIDTH];
                    w_clr[i*CH_WIDTH +: CH_WIDTH] = write_en ? data_in[CH_WIDTH-1:0]
                                                             : r_evt[i*CH_WIDTH +: CH_WIDTH];
                end
            end
            if (w_off17 == 17'(2 * NUM_CH)) begin
                w_rdata[NUM_CH-1:0] = w_summary;
            end
        end
    end

    // New rises are ORed after the clear so a coincident set survives.
    assign w_evt_next = (r_evt & ~w_clr) | w_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_deb       <= '0;
            r_evt       <= '0;
            r_data_out  <= '0;
            r_hit       <= 1'b0;
            r_event_any <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_s1 <= ch_in;
            r_s2 <= r_s1;
            for (int b = 0; b < NB; b++) begin
                if (r_s2[b] == r_deb[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_MAX) begin
                    r_deb[b] <= r_s2[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + CW'(1);
                end
            end
            r_evt       <= w_evt_next;
            r_event_any <= |w_evt_next;
            r_hit       <= w_sel;
            r_data_out  <= (w_sel && !write_en) ? w_rdata : 16'h0000;
        end
    end

    assign data_out  = r_data_out;
    assign hit       = r_hit;
    assign event_any = r_event_any;

endmodule

// File: tb/tb_mmio_input_bank.sv
// Directed testbench for mmio_input_bank (NUM_CH=2, CH_WIDTH=5, DEBOUNCE_CYCLES=4, base F000).
`timescale 1ns/1ps

module tb_mmio_input_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        write_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        hit;
    logic [9:0]  ch_in;
    logic        event_any;

    int vecs = 0;
    int errs = 0;

    mmio_input_bank #(
        .NUM_CH(2), .CH_WIDTH(5), .BASE_ADDR(16'hF000), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_en(write_en), .data_in(data_in),
        .data_out(data_out), .hit(hit), .ch_in(ch_in), .event_any(event_any)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic h);
        addr = a; write_en = 1'b0;
        tick(1);
        d = data_out; h = hit;
        addr = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v, output logic [15:0] d, output logic h);
        addr = a; write_en = 1'b1; data_in = v;
        tick(1);
        d = data_out; h = hit;
        addr = 16'h0000; write_en = 1'b0; data_in = 16'h0000;
    endtask

    task automatic test_reset();
        logic [15:0] d; logic h;
        reset = 1'b1; ch_in = 10'h3FF; addr = 16'h0000; write_en = 1'b0; data_in = 16'h0000;
        tick(2);
        vecs++; if (data_out !== 16'h0000) begin $display("FAIL reset_data_out got %h exp 0000", data_out); errs++; end
        vecs++; if (hit !== 1'b0) begin $display("FAIL reset_hit got %b exp 0", hit); errs++; end
        vecs++; if (event_any !== 1'b0) begin $display("FAIL reset_event_any got %b exp 0", event_any); errs++; end
        reset = 1'b0;
        rd(16'hF000, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL post_reset_level0 got %h exp 0000", d); errs++; end
        vecs++; if (h !== 1'b1) begin $display("FAIL post_reset_hit got %b exp 1", h); errs++; end
        ch_in = 10'h000;
        tick(10);
        vecs++; if (event_any !== 1'b0) begin $display("FAIL glitch_event_any got %b exp 0", event_any); errs++; end
    endtask

    task automatic test_level_event();
        ch_in = 10'h180;
        addr = 16'hF002; write_en = 1'b0;
        tick(5);
        vecs++; if (event_any !== 1'b0) begin $display("FAIL lvl_event_early got %b exp 0", event_any); errs++; end
        vecs++; if (data_out !== 16'h0000) begin $display("FAIL lvl_early got %h exp 0000", data_out); errs++; end
        tick(1);
        vecs++; if (event_any !== 1'b1) begin $display("FAIL lvl_event_set got %b exp 1", event_any); errs++; end
        vecs++; if (data_out !== 16'h0000) begin $display("FAIL lvl_edge5 got %h exp 0000", data_out); errs++; end
        tick(1);
        vecs++; if (data_out !== 16'h000C) begin $display("FAIL lvl_settled got %h exp 000c", data_out); errs++; end
        addr = 16'h0000;
        tick(1);
        vecs++; if (hit !== 1'b0) begin $display("FAIL idle_hit got %b exp 0", hit); errs++; end
    endtask

    task automatic test_back_to_back();
        addr = 16'hF003; write_en = 1'b0;
        tick(1);
        vecs++; if (data_out !== 16'h000C) begin $display("FAIL b2b_first got %h exp 000c", data_out); errs++; end
        vecs++; if (event_any !== 1'b0) begin $display("FAIL b2b_event_any got %b exp 0", event_any); errs++; end
        tick(1);
        vecs++; if (data_out !== 16'h0000) begin $display("FAIL b2b_second got %h exp 0000", data_out); errs++; end
        addr = 16'h0000;
    endtask

    task automatic test_debounce_pulse();
        logic [15:0] d; logic h;
        ch_in = 10'h181; tick(3); ch_in = 10'h180; tick(10);
        rd(16'hF000, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL short_pulse_level got %h exp 0000", d); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL short_pulse_event got %h exp 0000", d); errs++; end
        ch_in = 10'h181; tick(4); ch_in = 10'h180; tick(12);
        vecs++; if (event_any !== 1'b1) begin $display("FAIL long_pulse_any got %b exp 1", event_any); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0001) begin $display("FAIL long_pulse_event got %h exp 0001", d); errs++; end
    endtask

    task automatic test_write_clear();
        logic [15:0] d; logic h;
        ch_in = 10'h183; tick(6); ch_in = 10'h180; tick(14);
        wr(16'hF001, 16'h0001, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL write_data_out got %h exp 0000", d); errs++; end
        vecs++; if (h !== 1'b1) begin $display("FAIL write_hit got %b exp 1", h); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0002) begin $display("FAIL w1c_remaining got %h exp 0002", d); errs++; end
        wr(16'hF000, 16'hFFFF, d, h);
        rd(16'hF000, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL ro_level0 got %h exp 0000", d); errs++; end
        wr(16'hF002, 16'hFFFF, d, h);
        rd(16'hF002, d, h);
        vecs++; if (d !== 16'h000C) begin $display("FAIL ro_level1 got %h exp 000c", d); errs++; end
    endtask

    task automatic test_read_set_collision();
        logic [15:0] d; logic h;
        ch_in = 10'h181; tick(10);
        ch_in = 10'h185;
        tick(5);
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0001) begin $display("FAIL collide_read got %h exp 0001", d); errs++; end
        vecs++; if (event_any !== 1'b1) begin $display("FAIL collide_any got %b exp 1", event_any); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0004) begin $display("FAIL collide_next got %h exp 0004", d); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL collide_drained got %h exp 0000", d); errs++; end
        ch_in = 10'h180; tick(10);
        vecs++; if (event_any !== 1'b0) begin $display("FAIL fall_no_event got %b exp 0", event_any); errs++; end
    endtask

    task automatic test_summary_decode();
        logic [15:0] d; logic h;
        ch_in = 10'h1A8; tick(8);
        rd(16'hF004, d, h);
        vecs++; if (d !== 16'h0003) begin $display("FAIL summary got %h exp 0003", d); errs++; end
        rd(16'h1234, d, h);
        vecs++; if (d !== 16'h0000 || h !== 1'b0) begin $display("FAIL miss_1234 got %h/%b exp 0000/0", d, h); errs++; end
        rd(16'hF005, d, h);
        vecs++; if (d !== 16'h0000 || h !== 1'b0) begin $display("FAIL miss_top got %h/%b exp 0000/0", d, h); errs++; end
        rd(16'hEFFF, d, h);
        vecs++; if (d !== 16'h0000 || h !== 1'b0) begin $display("FAIL miss_below got %h/%b exp 0000/0", d, h); errs++; end
        rd(16'hF001, d, h);
        vecs++; if (d !== 16'h0008) begin $display("FAIL evt0 got %h exp 0008", d); errs++; end
        rd(16'hF003, d, h);
        vecs++; if (d !== 16'h0001) begin $display("FAIL evt1 got %h exp 0001", d); errs++; end
        rd(16'hF004, d, h);
        vecs++; if (d !== 16'h0000 || h !== 1'b1) begin $display("FAIL summary_clear got %h/%b exp 0000/1", d, h); errs++; end
    endtask

    task automatic test_reset_midcount();
        logic [15:0] d; logic h;
        ch_in = 10'h1A9;
        tick(4);
        reset = 1'b1;
        tick(1);
        vecs++; if (event_any !== 1'b0 || hit !== 1'b0) begin $display("FAIL mid_reset got %b/%b exp 0/0", event_any, hit); errs++; end
        reset = 1'b0;
        tick(5);
        rd(16'hF000, d, h);
        vecs++; if (d !== 16'h0000) begin $display("FAIL requal_early got %h exp 0000", d); errs++; end
        vecs++; if (event_any !== 1'b1) begin $display("FAIL requal_any got %b exp 1", event_any); errs++; end
        rd(16'hF000, d, h);
        vecs++; if (d !== 16'h0009) begin $display("FAIL requal_level0 got %h exp 0009", d); errs++; end
        rd(16'hF002, d, h);
        vecs++; if (d !== 16'h000D) begin $display("FAIL requal_level1 got %h exp 000d", d); errs++; end
        rd(16'hF004, d, h);
        vecs++; if (d !== 16'h0003) begin $display("FAIL requal_summary got %h exp 0003", d); errs++; end
        rd(16'hF003, d, h);
        vecs++; if (d !== 16'h000D) begin $display("FAIL requal_evt1 got %h exp 000d", d); errs++; end
    endtask

    initial begin
        test_reset();
        test_level_event();
        test_back_to_back();
        test_debounce_pulse();
        test_write_clear();
        test_read_set_collision();
        test_summary_decode();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
